// File: rtl/usr_burst_shifter.sv
// usr_burst_shifter: WIDTH-bit universal shift register running multi-step command bursts.
// Optional macro USR_SERIAL_EN: fill bit from ser_in and live ser_out (otherwise fill 0, ser_out 0).
`default_nettype none

module usr_burst_shifter #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 4
) (
   input  logic               clk,
   input  logic               clear_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_mode,
   input  logic [COUNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0]   cmd_data,
   input  logic               ser_in,
   output logic [WIDTH-1:0]   data_out,
   output logic               ser_out,
   output logic               busy,
   output logic               done
);

   localparam int HALF = WIDTH / 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [COUNT_W-1:0] remaining, remaining_nxt;
   logic [2:0]         mode_q;
   logic [WIDTH-1:0]   load_q;
   logic [WIDTH-1:0]   shreg, shreg_nxt;
   logic               done_nxt;
   logic               transfer;
   logic               step_en;
   logic [2:0]         step_mode;
   logic [WIDTH-1:0]   step_load;
   logic               fill;
   logic               shift_bit;
   logic               shift_step;

`ifdef USR_SERIAL_EN
   assign fill = ser_in;
`else
   assign fill = 1'b0;
`endif

   // The acceptance cycle executes step 1 straight from the cmd_* inputs.
   always_comb begin
      transfer   = cmd_valid && (state == IDLE);
      step_en    = transfer || (state == RUN);
      step_mode  = transfer ? cmd_mode : mode_q;
      step_load  = transfer ? cmd_data : load_q;
      shreg_nxt  = shreg;
      shift_bit  = 1'b0;
      shift_step = 1'b0;
      if (step_en) begin
         case (step_mode)
            3'b001: begin
               shreg_nxt  = {shreg[WIDTH-2:0], fill};
               shift_bit  = shreg[WIDTH-1];
               shift_step = 1'b1;
            end
            3'b010: begin
               shreg_nxt  = {fill, shreg[WIDTH-1:1]};
               shift_bit  = shreg[0];
               shift_step = 1'b1;
            end
            3'b011:  shreg_nxt = step_load;
            3'b100:  shreg_nxt = ~shreg;
            3'b101:  shreg_nxt = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
            3'b110:  shreg_nxt = {shreg[0], shreg[WIDTH-1:1]};
            3'b111:  shreg_nxt = {shreg[HALF-1:0], shreg[WIDTH-1:HALF]};
            default: shreg_nxt = shreg;
         endcase
      end
   end

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      done_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (transfer) begin
               if (cmd_count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt     = RUN;
                  remaining_nxt = cmd_count;
               end
            end
         end
         RUN: begin
            remaining_nxt = remaining - COUNT_W'(1);
            if (remaining == COUNT_W'(1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state     <= IDLE;
         remaining <= '0;
         mode_q    <= '0;
         load_q    <= '0;
         shreg     <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         shreg     <= shreg_nxt;
         done      <= done_nxt;
         if (transfer) begin
            mode_q <= cmd_mode;
            load_q <= cmd_data;
         end
      end
   end

`ifdef USR_SERIAL_EN
   logic ser_q;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ser_q <= 1'b0;
      end else if (shift_step) begin
         ser_q <= shift_bit;
      end
   end

   assign ser_out = ser_q;
`else
   logic unused_serial;
   assign unused_serial = ser_in ^ shift_bit ^ shift_step;
   assign ser_out       = 1'b0;
`endif

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RUN);
   assign data_out  = shreg;

endmodule

`default_nettype wire

// File: tb/tb_usr_burst_shifter.sv
// tb_usr_burst_shifter: directed and randomized bursts checked against an arithmetic reference model.
`default_nettype none

module tb_usr_burst_shifter;

`ifdef USR_SERIAL_EN
   localparam bit SERIAL_EN = 1'b1;
`else
   localparam bit SERIAL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_mode = 3'd0;
   logic [3:0] cmd_count = 4'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       ser_in = 1'b0;
   logic [7:0] data_out;
   logic       ser_out;
   logic       busy;
   logic       done;

   int vectors = 0;
   int miscompares = 0;

   int m_reg = 0;
   int m_ser = 0;

   usr_burst_shifter #(.WIDTH(8), .COUNT_W(4)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_count (cmd_count),
      .cmd_data  (cmd_data),
      .ser_in    (ser_in),
      .data_out  (data_out),
      .ser_out   (ser_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // One step of the register, from the operation table using plain integer arithmetic.
   task automatic model_step(input int mode, input int ld, input int fin);
      int f;
      f = SERIAL_EN ? fin : 0;
      case (mode)
         1: begin
            if (SERIAL_EN) m_ser = (m_reg / 128) % 2;
            m_reg = (m_reg * 2 + f) % 256;
         end
         2: begin
            if (SERIAL_EN) m_ser = m_reg % 2;
            m_reg = m_reg / 2 + f * 128;
         end
         3: m_reg = ld;
         4: m_reg = 255 - m_reg;
         5: m_reg = (m_reg * 2) % 256 + m_reg / 128;
         6: m_reg = m_reg / 2 + (m_reg % 2) * 128;
         7: m_reg = (m_reg % 16) * 16 + m_reg / 16;
         default: m_reg = m_reg;
      endcase
   endtask

   // Issues a command at the current negedge and checks every step; stop_after > 0 truncates the run.
   // ser_mode: 0/1 = constant ser_in, 2 = random ser_in per step.
   task automatic run_cmd(input int mode, input int count, input int data,
                          input int ser_mode, input int stop_after);
      int nsteps;
      int fin;
      nsteps = (stop_after > 0) ? stop_after : count + 1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_before_cmd: got %b want 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_mode  = mode[2:0];
      cmd_count = count[3:0];
      cmd_data  = data[7:0];
      for (int k = 1; k <= nsteps; k++) begin
         ser_in = (ser_mode == 2) ? 1'($urandom % 2) : ser_mode[0];
         fin    = int'(ser_in);
         @(negedge clk);
         if (k == 1) begin
            cmd_valid = 1'b0;
            cmd_mode  = 3'($urandom);
            cmd_count = 4'($urandom);
            cmd_data  = 8'($urandom);
         end
         model_step(mode, data, fin);
         vectors++;
         if (data_out !== m_reg[7:0]) begin
            miscompares++;
            $display("FAIL data_step mode=%0d k=%0d: got %h want %h", mode, k, data_out, m_reg[7:0]);
         end
         vectors++;
         if (ser_out !== m_ser[0]) begin
            miscompares++;
            $display("FAIL ser_out_step mode=%0d k=%0d: got %b want %b", mode, k, ser_out, m_ser[0]);
         end
         vectors++;
         if (busy !== (k <= count)) begin
            miscompares++;
            $display("FAIL busy_step k=%0d count=%0d: got %b want %b", k, count, busy, (k <= count));
         end
         vectors++;
         if (done !== (k == count + 1)) begin
            miscompares++;
            $display("FAIL done_step k=%0d count=%0d: got %b want %b", k, count, done, (k == count + 1));
         end
      end
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || data_out !== m_reg[7:0]) begin
            miscompares++;
            $display("FAIL idle: got done=%b busy=%b ready=%b data=%h want 0 0 1 %h",
                     done, busy, cmd_ready, data_out, m_reg[7:0]);
         end
      end
   endtask

   task automatic test_reset;
      clear_n   = 1'b0;
      cmd_valid = 1'b1;
      cmd_mode  = 3'd3;
      cmd_data  = 8'hFF;
      repeat (3) @(negedge clk);
      vectors++;
      if (data_out !== 8'h00 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_hold: got data=%h ready=%b want 00 1", data_out, cmd_ready);
      end
      cmd_valid = 1'b0;
      clear_n   = 1'b1;
      m_reg = 0;
      m_ser = 0;
      @(negedge clk);
      vectors++;
      if (data_out !== 8'h00 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release: got data=%h ser=%b busy=%b done=%b ready=%b want 00 0 0 0 1",
                  data_out, ser_out, busy, done, cmd_ready);
      end
   endtask

   task automatic test_load;
      run_cmd(3, 0, 8'hA5, 0, 0);
      vectors++;
      if (data_out !== 8'hA5) begin
         miscompares++;
         $display("FAIL load_value: got %h want a5", data_out);
      end
      idle_check(2);
   endtask

   task automatic test_rotate;
      run_cmd(5, 2, 0, 0, 0);
      vectors++;
      if (data_out !== 8'h2D) begin
         miscompares++;
         $display("FAIL rotate_final: got %h want 2d", data_out);
      end
      idle_check(1);
   endtask

   task automatic test_shift;
      run_cmd(1, 3, 0, 1, 0);
      idle_check(1);
   endtask

   task automatic test_back_to_back;
      run_cmd(7, 0, 0, 0, 0);
      run_cmd(4, 1, 0, 0, 0);
      idle_check(1);
   endtask

   task automatic test_reset_abort;
      run_cmd(3, 0, 8'h01, 0, 0);
      run_cmd(6, 15, 0, 0, 5);
      clear_n = 1'b0;
      #1;
      m_reg = 0;
      m_ser = 0;
      vectors++;
      if (data_out !== 8'h00 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_reset: got data=%h ser=%b busy=%b done=%b ready=%b want 00 0 0 0 1",
                  data_out, ser_out, busy, done, cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_mode  = 3'd3;
      cmd_count = 4'd0;
      cmd_data  = 8'h77;
      repeat (2) @(negedge clk);
      vectors++;
      if (data_out !== 8'h00 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_transfer: got data=%h done=%b want 00 0", data_out, done);
      end
      cmd_valid = 1'b0;
      clear_n   = 1'b1;
      idle_check(2);
      run_cmd(3, 0, 8'h3C, 0, 0);
      idle_check(1);
   endtask

   task automatic test_random;
      int mode;
      int count;
      for (int n = 0; n < 40; n++) begin
         mode  = int'($urandom % 8);
         count = ($urandom % 5 == 0) ? int'($urandom % 16) : int'($urandom % 4);
         run_cmd(mode, count, int'($urandom % 256), 2, 0);
         idle_check(int'($urandom % 3));
      end
      idle_check(1);
   endtask

   initial begin
      test_reset();
      test_load();
      test_rotate();
      test_shift();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/usr_burst_shifter.md
# usr_burst_shifter

Parametrised successor to the team's 4-bit universal shift register. It holds a WIDTH-bit register and executes the same eight operations (hold, shift left/right, load, invert, rotate left/right, half-swap) as multi-cycle bursts of 1..2^COUNT_W steps. Commands arrive through a valid/ready handshake, and completion is signalled with a one-cycle done pulse. It sits between a command sequencer and any datapath consuming a parallel word or serial bit stream.

## Interface
- WIDTH, 8: register width; must be even and ≥2.
- COUNT_W, 4: width of the step-count field.
- clk  in  1  sole clock; all state updates on its rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; equals (state == IDLE).
- cmd_mode  in  3  operation code.
- cmd_count  in  COUNT_W  number of steps minus 1.
- cmd_data  in  WIDTH  load value, used only by mode 011.
- ser_in  in  1  serial fill bit; used only with USR_SERIAL_EN.
- data_out  out  WIDTH  register contents.
- ser_out  out  1  last bit shifted out.
- busy  out  1  state == RUN.
- done  out  1  one-cycle pulse after the final step of a command.

## Operation
- Modes applied per step (R = register):
  - 000: hold.
  - 001: shift left, R[i] ← R[i-1], R[0] ← fill.
  - 010: shift right, R[i] ← R[i+1], R[WIDTH-1] ← fill.
  - 011: R ← cmd_data (latched at acceptance).
  - 100: R ← ~R.
  - 101: rotate left by 1.
  - 110: rotate right by 1.
  - 111: rotate by WIDTH/2 (half swap).
- Fill bit is 0, or ser_in when USR_SERIAL_EN is defined.
- ser_out takes the bit leaving the register on each shift-mode (001/010) step. It holds its value on all other steps and while idle.
- A transfer occurs when cmd_valid && cmd_ready. Mode, count and data are latched at that edge; later changes to cmd_* are ignored.
- FSM states: IDLE and RUN.
  - IDLE with transfer and cmd_count = 0: apply one step, stay in IDLE, done ← 1.
  - IDLE with transfer and cmd_count = c > 0: apply step 1, remaining ← c, go to RUN.
  - RUN: apply one step per cycle, remaining ← remaining − 1. When remaining = 1, that step is the last: go to IDLE, done ← 1.
- A command performs exactly cmd_count + 1 steps.
- Back-to-back: in the cycle where done = 1, cmd_ready = 1, so a new command may transfer in that same cycle.
- Hold mode (000) with count c is a pure (c+1)-cycle delay with a done pulse.

## Timing
- Reset values: data_out = 0, ser_out = 0, busy = 0, done = 0, state IDLE, remaining = 0.
- cmd_ready reads 1 in the reset state, but no transfer occurs while clear_n is low.
- Reset asserted mid-burst aborts the burst immediately: no done pulse, and the rest of the burst is discarded.
- Latency: step k (k = 1..c+1) is visible on data_out after the k-th rising edge counted from the acceptance edge inclusive.
- done is high in the cycle following the last step's edge, for exactly one cycle.
- busy is high from the cycle after acceptance until the cycle of the last step's edge (c cycles); it is never high for c = 0.
- Outputs are registered, except cmd_ready, which decodes the registered state.

## Configuration
- USR_SERIAL_EN defined:
  - Fill bit for modes 001/010 is ser_in, sampled at each step edge.
  - ser_out tracks the bits shifted out as described under Operation.
- USR_SERIAL_EN undefined:
  - Fill bit is 0 and ser_in is ignored.
  - ser_out is tied to 0.
  - Port list is unchanged.

## Test plan
All scenarios use WIDTH = 8 and COUNT_W = 4.
- Reset: hold clear_n low, release -> data_out 0x00, ser_out 0, busy 0, done 0, cmd_ready 1.
- Load 0xA5, count 0 -> data_out 0xA5 after the acceptance edge; done high for exactly the next cycle; busy never high.
- Rotate left, count 2, from 0xA5 -> data_out steps 0x4B, 0x96, 0x2D; busy high 2 cycles; done one cycle after 0x2D appears.
- Shift left, count 3, from 0x2D:
  - Macro off -> data_out 0xD0, ser_out 0.
  - Macro on with ser_in = 1 -> data_out 0xDF; ser_out sequence 0, 0, 1, 0.
- Half swap, count 0, on 0xD0 -> 0x0D. Then invert, count 1 (issued back-to-back in the done cycle) -> 0xF2, then 0x0D; two done pulses total.
- Rotate right, count 15, from 0x01; drop clear_n after 5 steps -> data_out 0x00, busy 0, no done. A following load of 0x3C, count 0, completes normally.
